// File: rtl/fpumuls_retire_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fpoperations                                                         |
// | Shared FP constants, csrfpu raise-bit indices and retire entry type. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package fpoperations;

  localparam int c_FP_RES_W = 33;
  localparam int c_RAISE_W  = 11;

  // Raise-vector bit positions shared with the FP CSR
  localparam int c_CSRFPU_NX     = 0;
  localparam int c_CSRFPU_UF     = 1;
  localparam int c_CSRFPU_OF     = 2;
  localparam int c_CSRFPU_DZ     = 3;
  localparam int c_CSRFPU_NV     = 4;
  localparam int c_CSRFPU_DEN    = 5;
  localparam int c_CSRFPU_SNAN   = 6;
  localparam int c_CSRFPU_QNAN   = 7;
  localparam int c_CSRFPU_INF    = 8;
  localparam int c_CSRFPU_ZERO   = 9;
  localparam int c_CSRFPU_EXTOVF = 10;

  // Tag-independent part of a retire entry; the tag is appended by the
  // user since its width is a per-instance parameter.
  typedef struct packed {
    logic [c_FP_RES_W-1:0] res;
    logic [c_RAISE_W-1:0]  raise;
  } retire_body_t;

endpackage : fpoperations
`default_nettype wire

// File: rtl/fpumuls_retire_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fpumuls_retire_if                                                    |
// | Issue-credit and writeback handshake bundle of the multiply retire.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface fpumuls_retire_if #(
  parameter int TAG_W = 6
);
  import fpoperations::*;

  logic                  issue_en;
  logic [TAG_W-1:0]      issue_tag;
  logic                  issue_stall;
  logic                  out_valid;
  logic                  out_ready;
  logic [c_FP_RES_W-1:0] out_res;
  logic [TAG_W-1:0]      out_tag;
  logic [c_RAISE_W-1:0]  out_raise;
  logic                  out_trap;

  modport master (
    output issue_en, issue_tag, out_ready,
    input  issue_stall, out_valid, out_res, out_tag, out_raise, out_trap
  );

  modport slave (
    input  issue_en, issue_tag, out_ready,
    output issue_stall, out_valid, out_res, out_tag, out_raise, out_trap
  );

endinterface : fpumuls_retire_if
`default_nettype wire

// File: rtl/fpu_retire_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fpu_retire_fifo                                                      |
// | Sync FIFO with wrap-bit pointers, occupancy output, zero when empty. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fpu_retire_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  input  wire logic                   wr_en,
  input  wire logic [WIDTH-1:0]       wr_data,
  input  wire logic                   rd_en,
  output logic      [WIDTH-1:0]       rd_data,
  output logic                        full,
  output logic                        empty,
  output logic      [$clog2(DEPTH):0] count
);

  localparam int c_AW = $clog2(DEPTH);

  logic [c_AW:0]      r_wr_ptr;
  logic [c_AW:0]      r_rd_ptr;
  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic               w_push;
  logic               w_pop;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                 (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign count = r_wr_ptr - r_rd_ptr;

  // A pop frees the slot the write lands in, so full+pop still accepts.
  assign w_pop  = rd_en & ~empty;
  assign w_push = wr_en & (~full | w_pop);

  assign rd_data = empty ? '0 : r_mem[r_rd_ptr[c_AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[c_AW-1:0]] <= wr_data;
        r_wr_ptr                  <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule : fpu_retire_fifo
`default_nettype wire

// File: rtl/fpumuls_retire.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fpumuls_retire                                                       |
// | Multiplier retire stage: in-flight tracking, result FIFO, credit,    |
// | sticky exception flags and trap indication.                          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fpumuls_retire
  import fpoperations::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6,
  parameter int LAT   = 2
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  fpumuls_retire_if.slave            bus,
  input  wire logic [c_FP_RES_W-1:0] mul_res,
  input  wire logic [c_RAISE_W-1:0]  mul_raise,
  input  wire logic [c_RAISE_W-1:0]  trap_mask,
  input  wire logic                  flag_clr,
  output logic      [c_RAISE_W-1:0]  flag_sticky,
  output logic                       ovf_err
);

  typedef struct packed {
    retire_body_t     body;
    logic [TAG_W-1:0] tag;
  } entry_t;

  localparam int c_CNT_W = $clog2(DEPTH) + 1;
  localparam int c_SUM_W = $clog2(DEPTH + LAT + 1);

  logic [LAT-1:0]       r_pipe_vld;
  logic [TAG_W-1:0]     r_pipe_tag [LAT];
  logic [c_RAISE_W-1:0] r_sticky;
  logic                 r_ovf;

  entry_t               w_wr_entry;
  entry_t               w_head;
  logic                 w_capture;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic [c_CNT_W-1:0]   w_count;
  logic [c_SUM_W-1:0]   w_inflight;

  // In-flight pipe: stage 0 samples the issue every cycle, regardless of stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pipe_vld <= '0;
      for (int i = 0; i < LAT; i++) begin
        r_pipe_tag[i] <= '0;
      end
    end else begin
      r_pipe_vld[0] <= bus.issue_en;
      r_pipe_tag[0] <= bus.issue_tag;
      for (int i = 1; i < LAT; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_tag[i] <= r_pipe_tag[i-1];
      end
    end
  end

  assign w_capture             = r_pipe_vld[LAT-1];
  assign w_wr_entry.body.res   = mul_res;
  assign w_wr_entry.body.raise = mul_raise;
  assign w_wr_entry.tag        = r_pipe_tag[LAT-1];

  fpu_retire_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_capture),
    .wr_data (w_wr_entry),
    .rd_en   (bus.out_ready),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .count   (w_count)
  );

  assign w_pop = ~w_empty & bus.out_ready;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < LAT; i++) begin
      w_inflight = w_inflight + c_SUM_W'(r_pipe_vld[i]);
    end
  end

  // Credit counts ops already launched, so a same-cycle pop relaxes it only next cycle.
  assign bus.issue_stall = (c_SUM_W'(w_count) + w_inflight) >= c_SUM_W'(DEPTH);

  assign bus.out_valid = ~w_empty;
  assign bus.out_res   = w_head.body.res;
  assign bus.out_raise = w_head.body.raise;
  assign bus.out_tag   = w_head.tag;
  assign bus.out_trap  = (|(w_head.body.raise & trap_mask)) & ~w_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sticky <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_pop) begin
        r_sticky <= flag_clr ? w_head.body.raise : (r_sticky | w_head.body.raise);
      end else if (flag_clr) begin
        r_sticky <= '0;
      end
      if (w_capture && w_full && !w_pop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign flag_sticky = r_sticky;
  assign ovf_err     = r_ovf;

endmodule : fpumuls_retire
`default_nettype wire
